// File: rtl/z85_prefix_fetch.sv
// Z85 instruction-assembly stage: folds DD/FD/ED/CB prefixes and the IX/IY
// displacement into one instruction word handed to the execute sequencer.
module z85_prefix_fetch #(
    parameter int PC_W     = 16,
    parameter int M1_CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic [7:0]          byte_data,
    input  logic [PC_W-1:0]     byte_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [1:0]          instr_grp,
    output logic [1:0]          instr_idx,
    output logic [7:0]          instr_op,
    output logic [7:0]          instr_disp,
    output logic                instr_disp_valid,
    output logic [PC_W-1:0]     instr_pc,
    output logic [M1_CNT_W-1:0] instr_m1_cnt,
    output logic                m1_pulse,
    output logic                at_boundary
);

    typedef enum logic [2:0] {
        S_OP      = 3'd0,
        S_DISP    = 3'd1,
        S_ED      = 3'd2,
        S_CB      = 3'd3,
        S_DDCB_D  = 3'd4,
        S_DDCB_OP = 3'd5
    } state_e;

    localparam logic [1:0] GRP_BASE = 2'd0;
    localparam logic [1:0] GRP_CB   = 2'd1;
    localparam logic [1:0] GRP_ED   = 2'd2;
    localparam logic [1:0] GRP_DDCB = 2'd3;
    localparam logic [1:0] IDX_HL   = 2'd0;
    localparam logic [1:0] IDX_IX   = 2'd1;
    localparam logic [1:0] IDX_IY   = 2'd2;
    localparam logic [M1_CNT_W-1:0] CNT_MAX = '1;

    // Base opcodes that address (HL); under DD/FD they become (IX+d)/(IY+d).
    // HALT (76) is the one 01xxxxxx code with both fields = 110 and is excluded.
    function automatic logic base_uses_hl_indirect(input logic [7:0] op);
        logic res;
        res = 1'b0;
        if (op[7:6] == 2'b01)
            res = (op[2:0] == 3'b110) != (op[5:3] == 3'b110);
        else if (op[7:6] == 2'b10)
            res = (op[2:0] == 3'b110);
        else if (op == 8'h34 || op == 8'h35 || op == 8'h36)
            res = 1'b1;
        return res;
    endfunction

    state_e                r_state;
    logic [1:0]            r_idx;
    logic [M1_CNT_W-1:0]   r_cnt;
    logic [PC_W-1:0]       r_pc;
    logic [7:0]            r_op;
    logic [7:0]            r_disp;
    logic                  r_live;

    logic                  r_instr_valid;
    logic [1:0]            r_grp;
    logic [1:0]            r_iidx;
    logic [7:0]            r_iop;
    logic [7:0]            r_idisp;
    logic                  r_idv;
    logic [PC_W-1:0]       r_ipc;
    logic [M1_CNT_W-1:0]   r_icnt;

    state_e                w_state_next;
    logic [1:0]            w_idx_next;
    logic [M1_CNT_W-1:0]   w_cnt_next;
    logic [PC_W-1:0]       w_pc_next;
    logic [7:0]            w_op_next;
    logic [7:0]            w_disp_next;
    logic                  w_acc;
    logic                  w_m1;
    logic                  w_emit;
    logic [1:0]            w_e_grp;
    logic [1:0]            w_e_idx;
    logic [7:0]            w_e_op;
    logic [7:0]            w_e_disp;
    logic                  w_e_dv;
    logic [PC_W-1:0]       w_e_pc;
    logic [M1_CNT_W-1:0]   w_e_cnt;
    logic [M1_CNT_W-1:0]   w_cnt_inc;
    logic [PC_W-1:0]       w_pc_start;

    assign byte_ready = r_live & (~r_instr_valid | instr_ready);
    assign w_acc      = byte_valid & byte_ready & ~rst;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + M1_CNT_W'(1);
    // A zero count in S_OP means no prefix yet: this byte starts the instruction.
    assign w_pc_start = (r_cnt == '0) ? byte_pc : r_pc;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_pc_next    = r_pc;
        w_op_next    = r_op;
        w_disp_next  = r_disp;
        w_m1         = 1'b0;
        w_emit       = 1'b0;
        w_e_grp      = GRP_BASE;
        w_e_idx      = r_idx;
        w_e_op       = byte_data;
        w_e_disp     = 8'h00;
        w_e_dv       = 1'b0;
        w_e_pc       = r_pc;
        w_e_cnt      = r_cnt;

        if (w_acc) begin
            unique case (r_state)
                S_OP: begin
                    w_m1       = 1'b1;
                    w_cnt_next = w_cnt_inc;
                    w_pc_next  = w_pc_start;
                    if (byte_data == 8'hDD) begin
                        w_idx_next = IDX_IX;
                    end else if (byte_data == 8'hFD) begin
                        w_idx_next = IDX_IY;
                    end else if (byte_data == 8'hED) begin
                        w_state_next = S_ED;
                    end else if (byte_data == 8'hCB) begin
                        w_state_next = (r_idx == IDX_HL) ? S_CB : S_DDCB_D;
                    end else if (r_idx != IDX_HL && base_uses_hl_indirect(byte_data)) begin
                        w_op_next    = byte_data;
                        w_state_next = S_DISP;
                    end else begin
                        w_emit  = 1'b1;
                        w_e_pc  = w_pc_start;
                        w_e_cnt = w_cnt_inc;
                    end
                end
                S_DISP: begin
                    w_emit   = 1'b1;
                    w_e_op   = r_op;
                    w_e_disp = byte_data;
                    w_e_dv   = 1'b1;
                end
                S_ED: begin
                    w_m1    = 1'b1;
                    w_emit  = 1'b1;
                    w_e_grp = GRP_ED;
                    w_e_idx = IDX_HL;
                    w_e_cnt = w_cnt_inc;
                end
                S_CB: begin
                    w_m1    = 1'b1;
                    w_emit  = 1'b1;
                    w_e_grp = GRP_CB;
                    w_e_idx = IDX_HL;
                    w_e_cnt = w_cnt_inc;
                end
                S_DDCB_D: begin
                    w_disp_next  = byte_data;
                    w_state_next = S_DDCB_OP;
                end
                S_DDCB_OP: begin
                    w_emit   = 1'b1;
                    w_e_grp  = GRP_DDCB;
                    w_e_disp = r_disp;
                    w_e_dv   = 1'b1;
                end
                default: w_state_next = S_OP;
            endcase
        end

        if (w_emit) begin
            w_state_next = S_OP;
            w_idx_next   = IDX_HL;
            w_cnt_next   = '0;
        end

        if (flush) begin
            w_state_next = S_OP;
            w_idx_next   = IDX_HL;
            w_cnt_next   = '0;
            w_emit       = 1'b0;
            w_m1         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OP;
            r_idx   <= IDX_HL;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_op    <= 8'h00;
            r_disp  <= 8'h00;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_pc    <= w_pc_next;
            r_op    <= w_op_next;
            r_disp  <= w_disp_next;
            r_live  <= 1'b1;
        end
    end

    // Output word only loads on emit, which byte_ready already gates against a held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_valid <= 1'b0;
            r_grp         <= GRP_BASE;
            r_iidx        <= IDX_HL;
            r_iop         <= 8'h00;
            r_idisp       <= 8'h00;
            r_idv         <= 1'b0;
            r_ipc         <= '0;
            r_icnt        <= '0;
        end else begin
            if (flush)
                r_instr_valid <= 1'b0;
            else if (w_emit)
                r_instr_valid <= 1'b1;
            else if (instr_ready)
                r_instr_valid <= 1'b0;
            if (w_emit) begin
                r_grp   <= w_e_grp;
                r_iidx  <= w_e_idx;
                r_iop   <= w_e_op;
                r_idisp <= w_e_disp;
                r_idv   <= w_e_dv;
                r_ipc   <= w_e_pc;
                r_icnt  <= w_e_cnt;
            end
        end
    end

    assign instr_valid      = r_instr_valid;
    assign instr_grp        = r_grp;
    assign instr_idx        = r_iidx;
    assign instr_op         = r_iop;
    assign instr_disp       = r_idisp;
    assign instr_disp_valid = r_idv;
    assign instr_pc         = r_ipc;
    assign instr_m1_cnt     = r_icnt;
    assign m1_pulse         = w_m1 & ~rst;
    assign at_boundary      = (r_state == S_OP) && (r_cnt == '0) && (r_idx == IDX_HL);

endmodule

// File: tb/tb_z85_prefix_fetch.sv
// Scoreboard bench for z85_prefix_fetch: directed cases plus randomized
// instructions built from a field-level model of the Z85 prefix rules.
module tb_z85_prefix_fetch;

    logic        clk = 1'b0;
    logic        rst, flush, byte_valid, byte_ready;
    logic [7:0]  byte_data;
    logic [15:0] byte_pc;
    logic        instr_valid, instr_ready;
    logic [1:0]  instr_grp, instr_idx;
    logic [7:0]  instr_op, instr_disp;
    logic        instr_disp_valid;
    logic [15:0] instr_pc;
    logic [3:0]  instr_m1_cnt;
    logic        m1_pulse, at_boundary;

    z85_prefix_fetch #(.PC_W(16), .M1_CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_data(byte_data), .byte_pc(byte_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_grp(instr_grp), .instr_idx(instr_idx),
        .instr_op(instr_op), .instr_disp(instr_disp),
        .instr_disp_valid(instr_disp_valid), .instr_pc(instr_pc),
        .instr_m1_cnt(instr_m1_cnt), .m1_pulse(m1_pulse),
        .at_boundary(at_boundary)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  grp;
        logic [1:0]  idx;
        logic [7:0]  op;
        logic [7:0]  disp;
        logic        dv;
        logic [15:0] pc;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m1_seen = 0;
    int   ab_viol = 0;
    bit   watch_ab = 1'b0;
    int   rdy_mode = 1;
    int   txn = 0;

    // Opcodes whose (HL) operand becomes (IX+d)/(IY+d) under a DD/FD prefix.
    logic [7:0] idx_ops [25] = '{8'h34, 8'h35, 8'h36, 8'h46, 8'h4E, 8'h56, 8'h5E,
                                 8'h66, 8'h6E, 8'h7E, 8'h70, 8'h71, 8'h72, 8'h73,
                                 8'h74, 8'h75, 8'h77, 8'h86, 8'h8E, 8'h96, 8'h9E,
                                 8'hA6, 8'hAE, 8'hB6, 8'hBE};

    function automatic bit is_idx_op(input logic [7:0] op);
        for (int i = 0; i < 25; i++)
            if (idx_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t mk(input logic [1:0] g, input logic [1:0] x, input logic [7:0] o,
                                input logic [7:0] d, input logic v, input logic [15:0] p,
                                input int m1);
        exp_t e;
        e.grp = g; e.idx = x; e.op = o; e.disp = d; e.dv = v; e.pc = p;
        e.cnt = (m1 > 15) ? 4'd15 : 4'(m1);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [15:0] pc);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        byte_pc    = pc;
        forever begin
            #1;
            if (byte_ready) begin
                @(negedge clk);
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout: byte %02h never accepted", b);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    always @(negedge clk) begin
        if (rdy_mode == 0)      instr_ready = ($urandom_range(0, 3) != 0);
        else if (rdy_mode == 1) instr_ready = 1'b1;
        else                    instr_ready = 1'b0;
    end

    // Monitor: samples 1 time unit after the falling edge, i.e. the values
    // the DUT will see at the next rising edge.
    initial begin
        exp_t cur, held, e;
        bit   have_held;
        have_held = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (m1_pulse) m1_seen++;
            if (rst) begin
                have_held = 1'b0;
                continue;
            end
            if (watch_ab && at_boundary) ab_viol++;
            if (instr_valid) begin
                cur = mk(instr_grp, instr_idx, instr_op, instr_disp, instr_disp_valid,
                         instr_pc, int'(instr_m1_cnt));
                if (have_held) begin
                    checks++;
                    if (cur !== held) begin
                        errors++;
                        $display("FAIL hold_stable: got %h required %h", cur, held);
                    end
                end
                if (instr_ready) begin
                    have_held = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_instr: got op=%02h with none expected", instr_op);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL txn %0d: got grp=%0d idx=%0d op=%02h disp=%02h dv=%0d pc=%04h cnt=%0d required grp=%0d idx=%0d op=%02h disp=%02h dv=%0d pc=%04h cnt=%0d",
                                     txn, cur.grp, cur.idx, cur.op, cur.disp, cur.dv, cur.pc, cur.cnt,
                                     e.grp, e.idx, e.op, e.disp, e.dv, e.pc, e.cnt);
                        end else begin
                            $display("txn %0d ok grp=%0d idx=%0d op=%02h disp=%02h dv=%0d pc=%04h cnt=%0d",
                                     txn, cur.grp, cur.idx, cur.op, cur.disp, cur.dv, cur.pc, cur.cnt);
                        end
                    end
                    txn++;
                end else begin
                    held = cur;
                    have_held = 1'b1;
                end
            end else begin
                have_held = 1'b0;
            end
        end
    end

    initial begin
        int          base;
        logic [15:0] cur_pc;
        rst = 1'b1; flush = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_pc = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_word", {instr_grp, instr_idx, instr_op, instr_disp, instr_disp_valid, 3'b000, instr_m1_cnt},
            32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_m1_pulse", 32'(m1_pulse), 32'd0);
        chk("rst_at_boundary", 32'(at_boundary), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("post_rst_byte_ready", 32'(byte_ready), 32'd1);
        @(negedge clk);

        // Single base opcode, one-cycle latency
        exp_q.push_back(mk(2'd0, 2'd0, 8'h3E, 8'h00, 1'b0, 16'h0010, 1));
        send_byte(8'h3E, 16'h0010);
        #1 chk("latency_valid", 32'(instr_valid), 32'd1);
        @(negedge clk);
        drain();

        // DD 7E 05
        exp_q.push_back(mk(2'd0, 2'd1, 8'h7E, 8'h05, 1'b1, 16'h0100, 2));
        send_byte(8'hDD, 16'h0100);
        send_byte(8'h7E, 16'h0101);
        send_byte(8'h05, 16'h0102);
        drain();

        // FD CB F0 46
        base = m1_seen;
        exp_q.push_back(mk(2'd3, 2'd2, 8'h46, 8'hF0, 1'b1, 16'h0200, 2));
        send_byte(8'hFD, 16'h0200);
        send_byte(8'hCB, 16'h0201);
        send_byte(8'hF0, 16'h0202);
        send_byte(8'h46, 16'h0203);
        drain();
        chk("ddcb_m1_pulses", 32'(m1_seen - base), 32'd2);

        // DD FD DD ED B0
        ab_viol = 0;
        exp_q.push_back(mk(2'd2, 2'd0, 8'hB0, 8'h00, 1'b0, 16'h0300, 5));
        send_byte(8'hDD, 16'h0300);
        watch_ab = 1'b1;
        send_byte(8'hFD, 16'h0301);
        send_byte(8'hDD, 16'h0302);
        send_byte(8'hED, 16'h0303);
        send_byte(8'hB0, 16'h0304);
        watch_ab = 1'b0;
        drain();
        chk("chain_at_boundary_low", 32'(ab_viol), 32'd0);
        #1 chk("boundary_after_emit", 32'(at_boundary), 32'd1);
        @(negedge clk);

        // Backpressure then back-to-back release
        rdy_mode = 2;
        @(negedge clk);
        exp_q.push_back(mk(2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 16'h0400, 1));
        exp_q.push_back(mk(2'd0, 2'd0, 8'h3E, 8'h00, 1'b0, 16'h0401, 1));
        send_byte(8'h00, 16'h0400);
        byte_valid = 1'b1; byte_data = 8'h3E; byte_pc = 16'h0401;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_byte_ready_low", 32'(byte_ready), 32'd0);
            chk("bp_held_op", {23'd0, instr_valid, instr_op}, {23'd0, 1'b1, 8'h00});
            if (k == 2) rdy_mode = 1;
            @(negedge clk);
        end
        send_byte(8'h3E, 16'h0401);
        #1 chk("no_bubble", {23'd0, instr_valid, instr_op}, {23'd0, 1'b1, 8'h3E});
        @(negedge clk);
        drain();

        // DD CB, flush with 12 offered, then 00
        base = m1_seen;
        send_byte(8'hDD, 16'h0500);
        send_byte(8'hCB, 16'h0501);
        flush = 1'b1; byte_valid = 1'b1; byte_data = 8'h12; byte_pc = 16'h0502;
        @(negedge clk);
        flush = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk(2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 16'h0503, 1));
        send_byte(8'h00, 16'h0503);
        drain();
        chk("flush_m1_pulses", 32'(m1_seen - base), 32'd3);

        // Same sequence with reset instead of flush
        base = m1_seen;
        send_byte(8'hDD, 16'h0500);
        send_byte(8'hCB, 16'h0501);
        rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h12; byte_pc = 16'h0502;
        @(negedge clk);
        rst = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk(2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 16'h0503, 1));
        send_byte(8'h00, 16'h0503);
        drain();
        chk("rst_m1_pulses", 32'(m1_seen - base), 32'd3);

        // 17 prefixes + op: M1 count saturates at 15
        exp_q.push_back(mk(2'd0, 2'd1, 8'h3E, 8'h00, 1'b0, 16'h0600, 18));
        for (int i = 0; i < 17; i++)
            send_byte((i % 2 == 0) ? 8'hDD : 8'hFD, 16'h0600 + 16'(i));
        send_byte(8'h3E, 16'h0611);
        drain();

        // Randomized instructions under random consumer backpressure
        rdy_mode = 0;
        cur_pc = 16'h1000;
        for (int t = 0; t < 150; t++) begin
            logic [7:0] bq[$];
            logic [7:0] op, d, p;
            logic [1:0] li;
            int         np, kind, m1;
            exp_t       e;
            bq.delete();
            np = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 2));
            li = 2'd0;
            for (int i = 0; i < np; i++) begin
                p = ($urandom_range(0, 1) == 1) ? 8'hDD : 8'hFD;
                bq.push_back(p);
                li = (p == 8'hDD) ? 2'd1 : 2'd2;
            end
            kind = int'($urandom_range(0, 3));
            op = 8'($urandom_range(0, 255));
            d  = 8'($urandom_range(0, 255));
            if (kind == 0 || kind == 1) begin
                if (kind == 1) op = idx_ops[$urandom_range(0, 24)];
                while (op == 8'hDD || op == 8'hFD || op == 8'hED || op == 8'hCB)
                    op = 8'($urandom_range(0, 255));
                bq.push_back(op);
                if (li != 2'd0 && is_idx_op(op)) begin
                    bq.push_back(d);
                    e = mk(2'd0, li, op, d, 1'b1, cur_pc, np + 1);
                end else begin
                    e = mk(2'd0, li, op, 8'h00, 1'b0, cur_pc, np + 1);
                end
            end else if (kind == 2) begin
                bq.push_back(8'hED);
                bq.push_back(op);
                e = mk(2'd2, 2'd0, op, 8'h00, 1'b0, cur_pc, np + 2);
            end else if (np == 0) begin
                bq.push_back(8'hCB);
                bq.push_back(op);
                e = mk(2'd1, 2'd0, op, 8'h00, 1'b0, cur_pc, 2);
            end else begin
                bq.push_back(8'hCB);
                bq.push_back(d);
                bq.push_back(op);
                e = mk(2'd3, li, op, d, 1'b1, cur_pc, np + 1);
            end
            m1 = 0;
            exp_q.push_back(e);
            foreach (bq[i]) begin
                send_byte(bq[i], cur_pc);
                cur_pc = cur_pc + 16'd1;
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            if ($urandom_range(0, 7) == 0) cur_pc = 16'($urandom_range(0, 65535));
        end
        rdy_mode = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z85_prefix_fetch.md
Name: z85_prefix_fetch

Overview:
- Instruction-assembly stage directly upstream of the Z85 decode helpers.
- Consumes the opcode byte stream from the fetch unit and tracks DD/FD/ED/CB prefix state, including the DD/FD+CB+d+op form.
- Collects the IX/IY displacement byte where one is required.
- Presents one fully assembled instruction (group, index select, opcode, displacement, M1 count) to the execute sequencer over a valid/ready handshake.

Parameters:
- PC_W, 16, width of instruction address.
- M1_CNT_W, 4, width of M1-cycle counter (saturating).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high. Single clock domain.
- flush  in  1  discard any partial or held instruction (branch/interrupt redirect).
- byte_valid  in  1  fetch byte available.
- byte_ready  out  1  stage accepts byte this cycle.
- byte_data  in  8  fetched byte.
- byte_pc  in  PC_W  address of byte_data.
- instr_valid  out  1  assembled instruction held.
- instr_ready  in  1  consumer accepts instruction.
- instr_grp  out  2  0=BASE, 1=CB, 2=ED, 3=DDCB (same encoding as z85_grp_e).
- instr_idx  out  2  0=HL, 1=IX, 2=IY.
- instr_op  out  8  final opcode byte.
- instr_disp  out  8  displacement d (0 when unused).
- instr_disp_valid  out  1  displacement present.
- instr_pc  out  PC_W  PC of first byte (first prefix) of instruction.
- instr_m1_cnt  out  M1_CNT_W  number of M1 (opcode-fetch) bytes; drives R increment.
- m1_pulse  out  1  one-cycle pulse per accepted M1 byte.
- at_boundary  out  1  high only in S_OP with no prefix pending (interrupt-acceptable point).

Behaviour:
- Reset:
  - state=S_OP; all instr_* outputs 0; instr_valid=0, m1_pulse=0, at_boundary=1.
  - byte_ready=1 after the first post-reset cycle.
- Handshake:
  - Byte transfer when byte_valid & byte_ready.
  - byte_ready = !instr_valid | instr_ready.
  - instr_* are registered and stable while instr_valid & !instr_ready.
- Latency: instr_valid asserts the cycle after the final byte is accepted. If the final byte and instr_ready coincide, the new instruction replaces the old with no bubble.
- States:
  - S_OP: expecting an M1 byte.
    - DD/FD → set idx=IX/IY, stay in S_OP.
    - ED → S_ED.
    - CB with idx=HL → S_CB.
    - CB with idx≠HL → S_DDCB_D.
    - Any other byte: if idx≠HL and base_uses_hl_indirect(byte), latch op → S_DISP. Otherwise emit BASE.
  - S_DISP: latch d, emit BASE with disp_valid=1.
  - S_ED: next byte (M1) emits ED with idx forced HL. A preceding DD/FD is discarded.
  - S_CB: next byte (M1) emits CB, idx=HL.
  - S_DDCB_D: latch d (not M1) → S_DDCB_OP.
  - S_DDCB_OP: op byte (not M1) emits DDCB with disp_valid=1.
- Prefix chains:
  - Repeated DD/FD: the last one wins. Each counts one M1 and stays in S_OP.
  - instr_pc holds the first prefix's PC.
  - DD/FD followed by ED or CB is never treated as a new index prefix.
- M1 accounting:
  - Increment on every accepted byte in S_OP, S_ED, S_CB; saturate at 2^M1_CNT_W-1.
  - m1_pulse mirrors each increment.
  - d bytes and the DDCB op byte do not count.
- Emit: load instr_* and set instr_valid; return to S_OP with idx=HL, count=0.
- Flush (highest priority):
  - Same-cycle effect: state→S_OP, idx/count cleared, instr_valid←0.
  - Any byte accepted that cycle is dropped; m1_pulse is suppressed.
- rst dominates flush.
- Immediate/address bytes (n, nn) are not collected here; the consumer fetches them.

Test Plan:
- Bytes 3E → one cycle later instr_valid=1: grp=0, idx=0, op=3E, disp_valid=0, m1_cnt=1.
- DD 7E 05 at pc 0x0100 → grp=0, idx=1, op=7E, disp=05, disp_valid=1, m1_cnt=2, instr_pc=0x0100.
- FD CB F0 46 → grp=3, idx=2, disp=F0, op=46, m1_cnt=2; exactly 2 m1_pulse.
- DD FD DD ED B0 → grp=2, idx=0, op=B0, m1_cnt=5, disp_valid=0; at_boundary low throughout the chain.
- Hold instr_ready=0 after 00 with byte_valid high → byte_ready=0; outputs stable ≥3 cycles. Raising instr_ready transfers both back-to-back with no bubble.
- DD CB, then flush in the next cycle with byte 12 offered → byte dropped; following 00 yields grp=0, idx=0, op=00, m1_cnt=1. Repeat with rst instead of flush → identical result.
